// File: rtl/video_cfg_ctrl_pkg.sv
// Shared types and helpers for the video configuration controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package video_cfg_pkg;

   // Word offsets inside the 16-byte register window (bridge_addr[3:2])
   localparam logic [1:0] OFS_CTRL   = 2'd0;
   localparam logic [1:0] OFS_FX     = 2'd1;
   localparam logic [1:0] OFS_COMMIT = 2'd2;
   localparam logic [1:0] OFS_STATUS = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARMED,
      ST_APPLY
   } cfg_state_t;

   // One set of mixer controls; used for both the shadow and the live copy
   typedef struct packed {
      logic       grayscale;
      logic [2:0] preset;
      logic [3:0] scnl;
      logic [3:0] smask;
   } video_cfg_t;

   // Reverse byte order of a 32-bit bridge word
   function automatic logic [31:0] bswap32(input logic [31:0] v);
      return {v[7:0], v[15:8], v[23:16], v[31:24]};
   endfunction

endpackage

// File: rtl/video_cfg_ctrl_if.sv
// APF bridge register-access bundle between the bridge decoder and the controller.
// Latency: n/a (wires only); read data is registered by the slave.
// Backpressure: none, strobes are single-cycle and always accepted.
interface video_cfg_ctrl_if;

   logic        bridge_endian_little;
   logic [31:0] bridge_addr;
   logic        bridge_wr;
   logic [31:0] bridge_wr_data;
   logic        bridge_rd;
   logic [31:0] bridge_rd_data;

   modport master (
      output bridge_endian_little,
      output bridge_addr,
      output bridge_wr,
      output bridge_wr_data,
      output bridge_rd,
      input  bridge_rd_data
   );

   modport slave (
      input  bridge_endian_little,
      input  bridge_addr,
      input  bridge_wr,
      input  bridge_wr_data,
      input  bridge_rd,
      output bridge_rd_data
   );

endinterface

// File: rtl/video_cfg_ctrl.sv
// Shadowed video mixer controls, committed to live outputs only at a frame boundary.
// Latency: read data 1 cycle after bridge_rd; live update 2 cycles after the vsync edge.
// Backpressure: none, bridge strobes are always accepted; commits wait on dataslot_allcomplete.
module video_cfg_ctrl
   import video_cfg_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE  = 32'hF000_1000,
   parameter logic [23:0] VS_TIMEOUT = 24'd2_500_000
) (
   input  logic             clk_74a,
   input  logic             reset,
   video_cfg_ctrl_if.slave  bridge,
   input  logic             dataslot_allcomplete,
   input  logic             vs_sync,
   output logic             grayscale_en,
   output logic [2:0]       video_preset,
   output logic [3:0]       scnl_sw,
   output logic [3:0]       smask_sw,
   output logic             cfg_pending,
   output logic             cfg_applied
);

   video_cfg_t  shadow;
   video_cfg_t  live;
   cfg_state_t  state;
   logic [23:0] tmo_cnt;
   logic [7:0]  apply_cnt;
   logic        vs_prev;

   logic        hit;
   logic [1:0]  ofs;
   logic [31:0] wdat;
   logic [31:0] rd_raw;
   logic        commit_wr;
   logic        vs_rise;
   logic        tmo_hit;

   assign hit       = (bridge.bridge_addr[31:4] == ADDR_BASE[31:4]);
   assign ofs       = bridge.bridge_addr[3:2];
   assign wdat      = bridge.bridge_endian_little ? bridge.bridge_wr_data
                                                  : bswap32(bridge.bridge_wr_data);
   assign commit_wr = hit && bridge.bridge_wr && (ofs == OFS_COMMIT);
   assign vs_rise   = vs_sync && !vs_prev;
   assign tmo_hit   = (tmo_cnt == VS_TIMEOUT - 24'd1);

   // Byte-lane and word-alignment bits that carry no register content
   logic unused_ok;
   assign unused_ok = &{1'b0, bridge.bridge_addr[1:0], wdat[31:12], wdat[7]};

   assign grayscale_en = live.grayscale;
   assign video_preset = live.preset;
   assign scnl_sw      = live.scnl;
   assign smask_sw     = live.smask;

   // Shadow registers: bridge writes land here immediately
   always_ff @(posedge clk_74a) begin
      if (reset) begin
         shadow <= '0;
      end else if (hit && bridge.bridge_wr) begin
         if (ofs == OFS_CTRL) begin
            shadow.grayscale <= wdat[0];
            shadow.preset    <= wdat[6:4];
         end else if (ofs == OFS_FX) begin
            shadow.scnl      <= wdat[3:0];
            shadow.smask     <= wdat[11:8];
         end
      end
   end

   // Readback mux for the addressed register, before byte-order correction
   always_comb begin
      rd_raw = '0;
      case (ofs)
         OFS_CTRL:   rd_raw = {25'd0, shadow.preset, 3'd0, shadow.grayscale};
         OFS_FX:     rd_raw = {20'd0, shadow.smask, 4'd0, shadow.scnl};
         OFS_COMMIT: rd_raw = '0;
         OFS_STATUS: rd_raw = {16'd0, apply_cnt, 6'd0, dataslot_allcomplete, cfg_pending};
         default:    rd_raw = '0;
      endcase
   end

   // Registered read data; misses keep the previous value
   always_ff @(posedge clk_74a) begin
      if (reset) begin
         bridge.bridge_rd_data <= '0;
      end else if (hit && bridge.bridge_rd) begin
         bridge.bridge_rd_data <= bridge.bridge_endian_little ? rd_raw : bswap32(rd_raw);
      end
   end

   // Previous vsync sample for rising-edge detection
   always_ff @(posedge clk_74a) begin
      if (reset) begin
         vs_prev <= 1'b0;
      end else begin
         vs_prev <= vs_sync;
      end
   end

   // Commit FSM: arm on COMMIT, wait for vsync edge or timeout, then copy shadow to live
   always_ff @(posedge clk_74a) begin
      if (reset) begin
         state       <= ST_IDLE;
         tmo_cnt     <= '0;
         apply_cnt   <= '0;
         live        <= '0;
         cfg_pending <= 1'b0;
         cfg_applied <= 1'b0;
      end else begin
         cfg_applied <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (commit_wr) begin
                  state       <= ST_ARMED;
                  tmo_cnt     <= '0;
                  cfg_pending <= 1'b1;
               end
            end
            ST_ARMED: begin
               if (!dataslot_allcomplete) begin
                  tmo_cnt <= '0;
               end else if (vs_rise || tmo_hit) begin
                  state <= ST_APPLY;
               end else begin
                  tmo_cnt <= tmo_cnt + 24'd1;
               end
            end
            ST_APPLY: begin
               // Non-blocking copy picks up the shadow as it was before any same-cycle write
               live        <= shadow;
               cfg_applied <= 1'b1;
               apply_cnt   <= apply_cnt + 8'd1;
               if (commit_wr) begin
                  state   <= ST_ARMED;
                  tmo_cnt <= '0;
               end else begin
                  state       <= ST_IDLE;
                  cfg_pending <= 1'b0;
               end
            end
            default: begin
               state       <= ST_IDLE;
               cfg_pending <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_video_cfg_ctrl.sv
// Scoreboard bench for video_cfg_ctrl: stimulus pushes expected reads and applies,
// a negedge monitor pops and compares whenever read data or cfg_applied appears.
module tb_video_cfg_ctrl;

   localparam logic [31:0] BASE = 32'hF000_1000;
   localparam logic [31:0] MISS = 32'hF000_2000;

   logic       clk_74a = 1'b0;
   logic       reset = 1'b1;
   logic       dataslot_allcomplete = 1'b1;
   logic       vs_sync = 1'b0;
   logic       grayscale_en;
   logic [2:0] video_preset;
   logic [3:0] scnl_sw;
   logic [3:0] smask_sw;
   logic       cfg_pending;
   logic       cfg_applied;

   always #5 clk_74a = ~clk_74a;

   video_cfg_ctrl_if bus ();

   video_cfg_ctrl #(
      .ADDR_BASE (BASE),
      .VS_TIMEOUT(24'd16)
   ) dut (
      .clk_74a             (clk_74a),
      .reset               (reset),
      .bridge              (bus),
      .dataslot_allcomplete(dataslot_allcomplete),
      .vs_sync             (vs_sync),
      .grayscale_en        (grayscale_en),
      .video_preset        (video_preset),
      .scnl_sw             (scnl_sw),
      .smask_sw            (smask_sw),
      .cfg_pending         (cfg_pending),
      .cfg_applied         (cfg_applied)
   );

   typedef struct {
      logic [11:0] cfg;
      int          at;
   } apply_exp_t;

   apply_exp_t  apply_q[$];
   logic [31:0] rd_q[$];
   int          n_checks = 0;
   int          n_pass = 0;
   int          cyc = 0;
   logic        rd_seen = 1'b0;
   int          e;

   always @(posedge clk_74a) begin
      cyc     <= cyc + 1;
      rd_seen <= bus.bridge_rd;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [11:0] mk(input logic g, input logic [2:0] p,
                                      input logic [3:0] s, input logic [3:0] m);
      return {g, p, s, m};
   endfunction

   // Monitor: compare whatever the DUT presents against the scoreboard queues
   always @(negedge clk_74a) begin
      if (rd_seen) begin
         if (rd_q.size() == 0) begin
            n_checks++;
            $display("FAIL rd_extra: read data 0x%08h with no expected value", bus.bridge_rd_data);
         end else begin
            chk("rd_data", bus.bridge_rd_data, rd_q.pop_front());
         end
      end
      if (cfg_applied) begin
         if (apply_q.size() == 0) begin
            n_checks++;
            $display("FAIL apply_extra: unexpected cfg_applied at cycle %0d", cyc);
         end else begin
            apply_exp_t x;
            x = apply_q.pop_front();
            chk("apply_live", {20'd0, grayscale_en, video_preset, scnl_sw, smask_sw}, {20'd0, x.cfg});
            chk("apply_cycle", cyc, x.at);
         end
      end
   end

   task automatic step();
      @(posedge clk_74a);
      #1;
      bus.bridge_wr = 1'b0;
      bus.bridge_rd = 1'b0;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bus.bridge_addr    = a;
      bus.bridge_wr_data = d;
      bus.bridge_wr      = 1'b1;
      step();
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] exp);
      rd_q.push_back(exp);
      bus.bridge_addr = a;
      bus.bridge_rd   = 1'b1;
      step();
   endtask

   task automatic exp_apply(input logic [11:0] c, input int at);
      apply_q.push_back('{cfg: c, at: at});
   endtask

   initial begin
      bus.bridge_endian_little = 1'b1;
      bus.bridge_addr          = '0;
      bus.bridge_wr            = 1'b0;
      bus.bridge_wr_data       = '0;
      bus.bridge_rd            = 1'b0;

      // Reset state
      reset = 1'b1;
      steps(3);
      reset = 1'b0;
      chk("rst_live", {20'd0, grayscale_en, video_preset, scnl_sw, smask_sw}, 32'd0);
      chk("rst_pending", {31'd0, cfg_pending}, 32'd0);
      chk("rst_applied", {31'd0, cfg_applied}, 32'd0);
      chk("rst_rd_data", bus.bridge_rd_data, 32'd0);
      rd(BASE + 32'h0, 32'h0);
      rd(BASE + 32'h4, 32'h0);
      rd(BASE + 32'h8, 32'h0);
      rd(BASE + 32'hC, 32'h2);

      // Shadow writes, commit, vsync-edge apply
      wr(BASE + 32'h0, 32'h51);
      wr(BASE + 32'h4, 32'h0A03);
      rd(BASE + 32'h0, 32'h51);
      rd(BASE + 32'h4, 32'h0A03);
      wr(BASE + 32'h8, 32'h0);
      chk("commit_pending", {31'd0, cfg_pending}, 32'd1);
      chk("live_before_apply", {20'd0, grayscale_en, video_preset, scnl_sw, smask_sw}, 32'd0);
      steps(2);
      vs_sync = 1'b1;
      exp_apply(mk(1'b1, 3'd5, 4'd3, 4'hA), cyc + 2);
      step();
      chk("pending_in_apply", {31'd0, cfg_pending}, 32'd1);
      step();
      vs_sync = 1'b0;
      steps(3);
      chk("pending_cleared", {31'd0, cfg_pending}, 32'd0);
      rd(BASE + 32'hC, 32'h0000_0102);

      // Forced commit on timeout with vsync held low
      wr(BASE + 32'h4, 32'h0507);
      wr(BASE + 32'h8, 32'h0);
      e = cyc;
      exp_apply(mk(1'b1, 3'd5, 4'd7, 4'd5), e + 17);
      steps(10);
      chk("timeout_pending", {31'd0, cfg_pending}, 32'd1);
      steps(10);
      chk("timeout_done", {31'd0, cfg_pending}, 32'd0);
      rd(BASE + 32'hC, 32'h0000_0202);

      // Commits blocked while dataslot_allcomplete is low
      dataslot_allcomplete = 1'b0;
      wr(BASE + 32'h0, 32'h30);
      wr(BASE + 32'h8, 32'h0);
      for (int i = 0; i < 3; i++) begin
         vs_sync = 1'b1;
         step();
         vs_sync = 1'b0;
         step();
      end
      steps(20);
      chk("blocked_pending", {31'd0, cfg_pending}, 32'd1);
      rd(BASE + 32'hC, 32'h0000_0201);
      dataslot_allcomplete = 1'b1;
      step();
      vs_sync = 1'b1;
      exp_apply(mk(1'b0, 3'd3, 4'd7, 4'd5), cyc + 2);
      step();
      vs_sync = 1'b0;
      steps(3);
      chk("unblocked_done", {31'd0, cfg_pending}, 32'd0);

      // CTRL write in the APPLY cycle: live takes the old shadow
      wr(BASE + 32'h0, 32'h41);
      wr(BASE + 32'h8, 32'h0);
      step();
      vs_sync = 1'b1;
      exp_apply(mk(1'b1, 3'd4, 4'd7, 4'd5), cyc + 2);
      step();
      vs_sync = 1'b0;
      wr(BASE + 32'h0, 32'h61);
      steps(2);
      rd(BASE + 32'h0, 32'h61);

      // COMMIT in the APPLY cycle re-arms; the new arm then times out
      wr(BASE + 32'h8, 32'h0);
      step();
      vs_sync = 1'b1;
      exp_apply(mk(1'b1, 3'd6, 4'd7, 4'd5), cyc + 2);
      step();
      vs_sync = 1'b0;
      wr(BASE + 32'h8, 32'h0);
      chk("rearm_pending", {31'd0, cfg_pending}, 32'd1);
      e = cyc;
      exp_apply(mk(1'b1, 3'd6, 4'd7, 4'd5), e + 17);
      steps(20);
      chk("rearm_done", {31'd0, cfg_pending}, 32'd0);
      rd(BASE + 32'hC, 32'h0000_0602);

      // Big-endian bridge data, address misses
      bus.bridge_endian_little = 1'b0;
      wr(BASE + 32'h0, 32'h5100_0000);
      rd(BASE + 32'h0, 32'h5100_0000);
      wr(BASE + 32'h8, 32'h0);
      step();
      vs_sync = 1'b1;
      exp_apply(mk(1'b1, 3'd5, 4'd7, 4'd5), cyc + 2);
      step();
      vs_sync = 1'b0;
      steps(3);
      rd(BASE + 32'hC, 32'h0207_0000);
      bus.bridge_endian_little = 1'b1;
      rd(MISS, 32'h0207_0000);
      wr(MISS, 32'hFF);
      rd(BASE + 32'h0, 32'h51);

      // Apply count wrap: 7 applies so far, 249 more reach 256 -> 0
      for (int i = 0; i < 249; i++) begin
         wr(BASE + 32'h8, 32'h0);
         vs_sync = 1'b1;
         exp_apply(mk(1'b1, 3'd5, 4'd7, 4'd5), cyc + 2);
         step();
         vs_sync = 1'b0;
         steps(2);
      end
      rd(BASE + 32'hC, 32'h0000_0002);

      // Reset while armed abandons the commit
      wr(BASE + 32'h8, 32'h0);
      steps(3);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rst_armed_pending", {31'd0, cfg_pending}, 32'd0);
      chk("rst_armed_live", {20'd0, grayscale_en, video_preset, scnl_sw, smask_sw}, 32'd0);
      steps(25);

      chk("apply_q_empty", apply_q.size(), 32'd0);
      chk("rd_q_empty", rd_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/video_cfg_ctrl.md
# video_cfg_ctrl

Bridge-programmable configuration controller for the Pocket video output path. Holds shadow copies of the video mixer controls (grayscale, preset, scanline and shadow-mask switches), written by the APF bridge. Shadow values are committed to the live outputs only at a frame boundary, so a settings change never tears mid-frame. The block sits in the `clk_74a` domain between the bridge decoder and the video mixer control inputs.

## Interface
Parameters:
- `ADDR_BASE`, 32'hF000_1000: base address of the 16-byte register window; bits [3:0] must be zero.
- `VS_TIMEOUT`, 24'd2_500_000: cycles to wait for a frame boundary before a forced commit.

Ports:
- `clk_74a`  in  1  APF main clock; the only clock.
- `reset`  in  1  synchronous, active-high.
- `bridge_endian_little`  in  1  1 = data is already little-endian; 0 = byte-swap `bridge_wr_data` and `bridge_rd_data`.
- `bridge_addr`  in  32  bridge address.
- `bridge_wr`  in  1  write strobe, one cycle.
- `bridge_wr_data`  in  32  write data.
- `bridge_rd`  in  1  read strobe, one cycle.
- `bridge_rd_data`  out  32  registered read data.
- `dataslot_allcomplete`  in  1  commits are blocked while low.
- `vs_sync`  in  1  core VSync, already synchronized to `clk_74a`.
- `grayscale_en`  out  1  live grayscale enable.
- `video_preset`  out  3  live preset.
- `scnl_sw`  out  4  live scanline switches.
- `smask_sw`  out  4  live shadow-mask switches.
- `cfg_pending`  out  1  a commit is armed and not yet applied.
- `cfg_applied`  out  1  one-cycle pulse when live registers are updated.

## Operation
- Address hit: `bridge_addr[31:4] == ADDR_BASE[31:4]`. Offset is `bridge_addr[3:2]`. Misses are ignored and leave `bridge_rd_data` unchanged.
- Write data `d` is after the optional byte swap.
- Register map:
  - 0x0 CTRL (RW shadow): `d[0]` grayscale, `d[6:4]` preset.
  - 0x4 FX (RW shadow): `d[3:0]` scnl, `d[11:8]` smask.
  - 0x8 COMMIT (WO): any write arms a commit. Reads return 0.
  - 0xC STATUS (RO): `[0]` pending, `[1]` `dataslot_allcomplete`, `[15:8]` 8-bit apply count (wraps 255→0). Writes ignored.
- Unused read bits return 0.
- FSM states: IDLE, ARMED, APPLY.
  - IDLE: a COMMIT write goes to ARMED and sets `cfg_pending`.
  - ARMED → APPLY when `dataslot_allcomplete` is high and either:
    - a rising edge of `vs_sync` is seen (`vs_sync` = 1, previous sample = 0), or
    - the timeout counter reaches `VS_TIMEOUT-1`.
  - ARMED with `dataslot_allcomplete` low: stay in ARMED and hold the timeout counter at 0.
  - APPLY (one cycle): copy shadow → live, pulse `cfg_applied`, increment apply count, clear `cfg_pending`, return to IDLE.
- The timeout counter clears on entry to ARMED and counts each ARMED cycle.
- Simultaneous events:
  - Shadow write during APPLY: live takes the pre-write shadow value; the new value stays in shadow until the next commit.
  - COMMIT during ARMED: no effect.
  - COMMIT during APPLY: go to ARMED (not IDLE), `cfg_pending` stays 1.
  - vs edge and timeout in the same cycle: a single APPLY.
- Reset values:
  - All shadow and live fields 0.
  - FSM IDLE, counters 0.
  - `cfg_pending` = 0, `cfg_applied` = 0, `bridge_rd_data` = 0.
  - Reset mid-ARMED abandons the commit.

## Timing
- Write to shadow: visible on readback the cycle after `bridge_wr`.
- Read latency: `bridge_rd_data` is valid on the cycle after `bridge_rd`.
- COMMIT write at posedge t: `cfg_pending` = 1 after t.
- vs edge sampled at posedge t (in ARMED): state APPLY after t. Live outputs and `cfg_applied` = 1 after t+1. `cfg_applied` = 0 again after t+2.
- Forced commit: counter = `VS_TIMEOUT-1` at posedge t, then live outputs update after t+1. This is `VS_TIMEOUT`+1 cycles after ARMED entry.
- Live outputs change only at the APPLY edge.

## Structure
- Package `video_cfg_pkg` holds:
  - register offset constants (CTRL, FX, COMMIT, STATUS);
  - FSM state enum;
  - packed struct `video_cfg_t` {grayscale, preset[2:0], scnl[3:0], smask[3:0]}, used for both shadow and live registers;
  - byte-swap function.
- Single module. No sub-module; edge detect and timeout stay inline.

## Test plan
- Reset, then read all four offsets → 0, 0, 0, 0x0000_0002 when `dataslot_allcomplete` = 1. All outputs 0.
- With `bridge_endian_little` = 1:
  - write CTRL = 0x51, FX = 0x0A03, COMMIT;
  - raise `vs_sync` at cycle t;
  - → `grayscale_en` = 1, `video_preset` = 5, `scnl_sw` = 3, `smask_sw` = 0xA after t+1, a single `cfg_applied` pulse, STATUS = 0x0000_0102.
- COMMIT with `vs_sync` held low, `VS_TIMEOUT` = 16 → forced apply exactly 17 cycles after ARMED entry.
- `dataslot_allcomplete` = 0, COMMIT, 3 vs edges → no apply, `cfg_pending` = 1. Raise `dataslot_allcomplete`, then next vs edge → apply.
- Edge cases:
  - CTRL write in the APPLY cycle → live gets the old value, shadow readback shows the new value;
  - COMMIT in the APPLY cycle → `cfg_pending` stays 1.
- Byte order and wrap:
  - `bridge_endian_little` = 0, write CTRL = 0x5100_0000 → preset 5, grayscale 1;
  - 256 commits → apply count wraps to 0.
